// File: rtl/expr_stream_checker.sv
// Character-serial arithmetic expression recogniser with bounded
// literal length and nesting depth, sticky error and error position.
module expr_stream_checker #(
  parameter int MAX_DIGITS    = 2,
  parameter int MAX_DEPTH     = 3,
  parameter int ALLOW_SUB_DIV = 0,
  parameter int POS_W         = 8
) (
  input  logic                           clk,
  input  logic                           clr,
  input  logic                           in_valid,
  input  logic [7:0]                     in,
  output logic                           out,
  output logic                           err,
  output logic [$clog2(MAX_DEPTH+1)-1:0] depth,
  output logic [POS_W-1:0]               err_pos
);

  localparam int DW = $clog2(MAX_DEPTH + 1);
  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam logic [DW-1:0] DMAX = DW'(MAX_DEPTH);
  localparam logic [CW-1:0] CMAX = CW'(MAX_DIGITS);

  typedef enum logic [2:0] {
    EXPECT_OPND,
    IN_ZERO,
    IN_NUM,
    AFTER_CLOSE,
    DEAD
  } state_t;

  state_t        state, state_n;
  logic [DW-1:0] depth_n;
  logic [CW-1:0] dcnt, dcnt_n;
  logic [POS_W-1:0] cnt;

  logic is_zero, is_nz, is_op, is_lp, is_rp;
  logic can_close;

  always_comb begin
    is_zero = (in == 8'd48);
    is_nz   = (in >= 8'd49) && (in <= 8'd57);
    is_op   = (in == 8'd43) || (in == 8'd42) ||
              ((ALLOW_SUB_DIV != 0) &&
               ((in == 8'd45) || (in == 8'd47)));
    is_lp   = (in == 8'd40);
    is_rp   = (in == 8'd41);
  end

  assign can_close = (depth != '0);

  always_comb begin
    state_n = state;
    depth_n = depth;
    dcnt_n  = dcnt;
    unique case (state)
      EXPECT_OPND: begin
        unique case (1'b1)
          is_zero: state_n = IN_ZERO;
          is_nz: begin
            state_n = IN_NUM;
            dcnt_n  = CW'(1);
          end
          is_lp: begin
            if (depth < DMAX) depth_n = depth + 1'b1;
            else              state_n = DEAD;
          end
          default: state_n = DEAD;
        endcase
      end
      IN_ZERO, AFTER_CLOSE: begin
        unique case (1'b1)
          is_op: state_n = EXPECT_OPND;
          is_rp: begin
            state_n = can_close ? AFTER_CLOSE : DEAD;
            if (can_close) depth_n = depth - 1'b1;
          end
          default: state_n = DEAD;
        endcase
      end
      IN_NUM: begin
        unique case (1'b1)
          is_zero, is_nz: begin
            if (dcnt < CMAX) dcnt_n = dcnt + 1'b1;
            else             state_n = DEAD;
          end
          is_op: state_n = EXPECT_OPND;
          is_rp: begin
            state_n = can_close ? AFTER_CLOSE : DEAD;
            if (can_close) depth_n = depth - 1'b1;
          end
          default: state_n = DEAD;
        endcase
      end
      default: state_n = DEAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state   <= EXPECT_OPND;
      depth   <= '0;
      dcnt    <= '0;
      cnt     <= '0;
      out     <= 1'b0;
      err     <= 1'b0;
      err_pos <= '0;
    end else if (in_valid) begin
      state <= state_n;
      depth <= depth_n;
      dcnt  <= dcnt_n;
      out   <= (state_n inside {IN_ZERO, IN_NUM, AFTER_CLOSE}) &&
               (depth_n == '0);
      err   <= (state_n == DEAD);
      // Position counting stops once dead so err_pos stays meaningful.
      if (state != DEAD) begin
        if (cnt != '1) cnt <= cnt + 1'b1;
        if (state_n == DEAD) err_pos <= cnt;
      end
    end
  end

endmodule

// File: tb/tb_expr_stream_checker.sv
// Scoreboard bench for expr_stream_checker: default instance plus an
// instance with the extra operators enabled, fed the same stream.
module tb_expr_stream_checker;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] ch_in = 8'd0;

  logic       out0, err0, out1, err1;
  logic [1:0] dep0, dep1;
  logic [7:0] pos0, pos1;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic       o;
    logic       e;
    logic [1:0] d;
    logic [7:0] p;
    bit         pc;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  expr_stream_checker u0 (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in(ch_in),
    .out(out0), .err(err0), .depth(dep0), .err_pos(pos0)
  );

  expr_stream_checker #(.ALLOW_SUB_DIV(1)) u1 (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in(ch_in),
    .out(out1), .err(err1), .depth(dep1), .err_pos(pos1)
  );

  function automatic exp_t mk(byte o, byte e, byte d, byte p);
    exp_t x;
    x.o  = (o == "1");
    x.e  = (e == "1");
    x.d  = 2'(d - 8'h30);
    x.pc = (p != "-");
    x.p  = x.pc ? 8'(p - 8'h30) : 8'd0;
    return x;
  endfunction

  task automatic step(input bit v, input bit r, input byte c);
    in_valid = v;
    clr      = r;
    ch_in    = c;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clr      = 1'b0;
  endtask

  task automatic test_reset();
    exp_t x;
    sb.push_back(mk("0", "0", "0", "0"));
    step(1'b1, 1'b1, "1");
    x = sb.pop_front();
    n_chk += 4;
    if (out0 !== x.o) begin n_fail++; $display("FAIL reset out got %b want %b", out0, x.o); end
    if (err0 !== x.e) begin n_fail++; $display("FAIL reset err got %b want %b", err0, x.e); end
    if (dep0 !== x.d) begin n_fail++; $display("FAIL reset depth got %0d want %0d", dep0, x.d); end
    if (pos0 !== x.p) begin n_fail++; $display("FAIL reset err_pos got %0d want %0d", pos0, x.p); end
  endtask

  task automatic test_stream(input string tn, input string c,
                             input string o, input string e,
                             input string d, input string p);
    exp_t x;
    step(1'b0, 1'b1, 8'd0);
    for (int i = 0; i < c.len(); i++) begin
      sb.push_back(mk(o[i], e[i], d[i], p[i]));
      step(1'b1, 1'b0, c[i]);
      x = sb.pop_front();
      n_chk += 3;
      if (out0 !== x.o) begin n_fail++; $display("FAIL %s[%0d] out got %b want %b", tn, i, out0, x.o); end
      if (err0 !== x.e) begin n_fail++; $display("FAIL %s[%0d] err got %b want %b", tn, i, err0, x.e); end
      if (dep0 !== x.d) begin n_fail++; $display("FAIL %s[%0d] depth got %0d want %0d", tn, i, dep0, x.d); end
      if (x.pc) begin
        n_chk++;
        if (pos0 !== x.p) begin n_fail++; $display("FAIL %s[%0d] err_pos got %0d want %0d", tn, i, pos0, x.p); end
      end
    end
  endtask

  task automatic test_sub_div();
    string c  = "9-8/(1)";
    string o1 = "1010001", e1 = "0000000", d1 = "0000110";
    string o0 = "1000000", e0 = "0111111", p0 = "-111111";
    exp_t x, y;
    step(1'b0, 1'b1, 8'd0);
    for (int i = 0; i < c.len(); i++) begin
      sb.push_back(mk(o1[i], e1[i], d1[i], "-"));
      sb.push_back(mk(o0[i], e0[i], "0", p0[i]));
      step(1'b1, 1'b0, c[i]);
      x = sb.pop_front();
      y = sb.pop_front();
      n_chk += 6;
      if (out1 !== x.o) begin n_fail++; $display("FAIL subdiv1[%0d] out got %b want %b", i, out1, x.o); end
      if (err1 !== x.e) begin n_fail++; $display("FAIL subdiv1[%0d] err got %b want %b", i, err1, x.e); end
      if (dep1 !== x.d) begin n_fail++; $display("FAIL subdiv1[%0d] depth got %0d want %0d", i, dep1, x.d); end
      if (out0 !== y.o) begin n_fail++; $display("FAIL subdiv0[%0d] out got %b want %b", i, out0, y.o); end
      if (err0 !== y.e) begin n_fail++; $display("FAIL subdiv0[%0d] err got %b want %b", i, err0, y.e); end
      if (dep0 !== y.d) begin n_fail++; $display("FAIL subdiv0[%0d] depth got %0d want %0d", i, dep0, y.d); end
      if (y.pc) begin
        n_chk++;
        if (pos0 !== y.p) begin n_fail++; $display("FAIL subdiv0[%0d] err_pos got %0d want %0d", i, pos0, y.p); end
      end
    end
  endtask

  task automatic test_valid_hold();
    string c = "4aa56", v = "10011";
    string o = "11110", e = "00001", p = "----2";
    exp_t x;
    step(1'b0, 1'b1, 8'd0);
    for (int i = 0; i < c.len(); i++) begin
      sb.push_back(mk(o[i], e[i], "0", p[i]));
      step(v[i] == "1", 1'b0, c[i]);
      x = sb.pop_front();
      n_chk += 3;
      if (out0 !== x.o) begin n_fail++; $display("FAIL hold[%0d] out got %b want %b", i, out0, x.o); end
      if (err0 !== x.e) begin n_fail++; $display("FAIL hold[%0d] err got %b want %b", i, err0, x.e); end
      if (dep0 !== x.d) begin n_fail++; $display("FAIL hold[%0d] depth got %0d want %0d", i, dep0, x.d); end
      if (x.pc) begin
        n_chk++;
        if (pos0 !== x.p) begin n_fail++; $display("FAIL hold[%0d] err_pos got %0d want %0d", i, pos0, x.p); end
      end
    end
  endtask

  task automatic test_clr_collision();
    string c = "1+)+(", r = "01010";
    string o = "10000", e = "00100", d = "00001", p = "-0000";
    exp_t x;
    step(1'b0, 1'b1, 8'd0);
    for (int i = 0; i < c.len(); i++) begin
      sb.push_back(mk(o[i], e[i], d[i], p[i]));
      step(1'b1, r[i] == "1", c[i]);
      x = sb.pop_front();
      n_chk += 3;
      if (out0 !== x.o) begin n_fail++; $display("FAIL clrcol[%0d] out got %b want %b", i, out0, x.o); end
      if (err0 !== x.e) begin n_fail++; $display("FAIL clrcol[%0d] err got %b want %b", i, err0, x.e); end
      if (dep0 !== x.d) begin n_fail++; $display("FAIL clrcol[%0d] depth got %0d want %0d", i, dep0, x.d); end
      if (x.pc) begin
        n_chk++;
        if (pos0 !== x.p) begin n_fail++; $display("FAIL clrcol[%0d] err_pos got %0d want %0d", i, pos0, x.p); end
      end
    end
  endtask

  task automatic test_saturate();
    exp_t x;
    step(1'b0, 1'b1, 8'd0);
    for (int i = 0; i < 150; i++) begin
      step(1'b1, 1'b0, "1");
      step(1'b1, 1'b0, "+");
    end
    x = '{o: 1'b1, e: 1'b0, d: 2'd0, p: 8'd0, pc: 1'b0};
    sb.push_back(x);
    step(1'b1, 1'b0, "1");
    x = sb.pop_front();
    n_chk += 2;
    if (out0 !== x.o) begin n_fail++; $display("FAIL sat_long out got %b want %b", out0, x.o); end
    if (err0 !== x.e) begin n_fail++; $display("FAIL sat_long err got %b want %b", err0, x.e); end
    x = '{o: 1'b0, e: 1'b1, d: 2'd0, p: 8'd255, pc: 1'b1};
    sb.push_back(x);
    step(1'b1, 1'b0, "a");
    x = sb.pop_front();
    n_chk += 3;
    if (out0 !== x.o) begin n_fail++; $display("FAIL sat_bad out got %b want %b", out0, x.o); end
    if (err0 !== x.e) begin n_fail++; $display("FAIL sat_bad err got %b want %b", err0, x.e); end
    if (pos0 !== x.p) begin n_fail++; $display("FAIL sat_bad err_pos got %0d want %0d", pos0, x.p); end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_stream("basic",  "12+0",    "1101",    "0000",    "0000",    "----");
    test_stream("digits", "123+4",   "11000",   "00111",   "00000",   "--222");
    test_stream("nest",   "((7)*5)", "0000001", "0000000", "1221110", "-------");
    test_stream("deep",   "((((",    "0000",    "0001",    "1233",    "---3");
    test_stream("lzero",  "05",      "10",      "01",      "00",      "-1");
    test_stream("rpfirst", ")1",     "00",      "11",      "00",      "00");
    test_sub_div();
    test_valid_hold();
    test_clr_collision();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/expr_stream_checker.md
Name: expr_stream_checker

Overview:
- Character-serial recogniser for arithmetic expressions, one ASCII byte per accepted cycle.
- `out` is 1 whenever the prefix received since the last reset is a complete, well-formed expression.
- Generalises the fixed single-level recogniser:
  - parametrised operand length and parenthesis nesting depth;
  - optional extra operators;
  - input-valid qualifier;
  - sticky error flag with error position.
- Sits after the character source in the P1 test datapath.

Parameters:
- MAX_DIGITS, 2: maximum digits per number literal (>=1).
- MAX_DEPTH, 3: maximum parenthesis nesting depth (>=1).
- ALLOW_SUB_DIV, 0: 1 adds '-' (45) and '/' (47) to the operator set; 0 accepts '+' (43) and '*' (42) only.
- POS_W, 8: width of the character counter and error position.

Ports:
- clk  in  1  clock, all state updates on posedge.
- clr  in  1  synchronous active-high reset.
- in_valid  in  1  `in` is consumed this cycle when 1.
- in  in  8  ASCII character.
- out  out  1  registered: received prefix is a complete valid expression.
- err  out  1  registered, sticky: prefix can never become valid.
- depth  out  $clog2(MAX_DEPTH+1)  current open-parenthesis count.
- err_pos  out  POS_W  index (0-based) of first offending character; valid while err=1.

Behaviour:
- Reset (clr=1 at posedge, dominates in_valid): state=EXPECT_OPND, depth=0, digit count=0, char count=0, out=0, err=0, err_pos=0.
- in_valid=0: every register holds; out, err and depth unchanged.
- Character classes:
  - ZERO = '0';
  - NZ = '1'..'9';
  - OP = '+', '*', plus '-' and '/' when ALLOW_SUB_DIV=1;
  - LP = '(';
  - RP = ')';
  - anything else = BAD.
- "Close" on RP: if depth>0, then depth-1 and go to AFTER_CLOSE; else DEAD.
- States and transitions (only on accepted characters):
  - EXPECT_OPND:
    - ZERO -> IN_ZERO.
    - NZ -> IN_NUM, dcnt=1.
    - LP -> if depth<MAX_DEPTH, depth+1 and stay; else DEAD.
    - Others -> DEAD.
  - IN_ZERO:
    - OP -> EXPECT_OPND.
    - RP -> close.
    - Others -> DEAD (leading zeros forbidden).
  - IN_NUM:
    - ZERO/NZ -> if dcnt<MAX_DIGITS, dcnt+1 and stay; else DEAD.
    - OP -> EXPECT_OPND.
    - RP -> close.
    - Others -> DEAD.
  - AFTER_CLOSE:
    - OP -> EXPECT_OPND.
    - RP -> close.
    - Others -> DEAD.
  - DEAD: absorbing until clr; depth frozen at its last value.
- Output timing:
  - out is registered alongside the state, so it reflects all characters accepted up to and including the previous posedge.
  - out_next = (next state in {IN_ZERO, IN_NUM, AFTER_CLOSE}) && (next depth==0).
- Error reporting:
  - err_next = (next state==DEAD).
  - On the transition into DEAD, err_pos captures the current char count; it holds afterwards.
- Char counter:
  - increments on every accepted character while not DEAD;
  - saturates at 2^POS_W-1 (no wrap);
  - err_pos reports the saturated value if the error lies beyond it.
- Depth arithmetic never over- or underflows: the guards above route both cases to DEAD.
- clr asserted in the same cycle as in_valid: the character is discarded and reset wins.

Test Plan:
- Defaults, clr, then "1","2","+","0" with in_valid=1 -> out after each: 1,1,0,1; err=0; depth=0.
- Defaults, "1","2","3" -> out 1,1,0; err=1 after the 3rd; err_pos=2; further "+","4" keep out=0, err=1.
- Defaults, "(","(","7",")","*","5",")" -> depth 1,2,2,1,1,1,0; out 0,0,0,0,0,0,1.
- Defaults, "(" x4 -> depth 1,2,3,3; err=1 after the 4th; err_pos=3. Separately, "0","5" -> err=1, err_pos=1 (leading zero).
- ALLOW_SUB_DIV=1, "9","-","8","/","(","1",")" -> out ends 1, err=0. Same stream with ALLOW_SUB_DIV=0 -> err=1, err_pos=1.
- Defaults:
  - "4" with in_valid toggling 1,0,0 -> out stays 1 and state holds.
  - "+" with clr=1 in the same cycle -> all outputs 0 next cycle.
  - ")" as the first character -> err=1, err_pos=0.
